// File: rtl/dsp_file_fifo_pkg.sv
// Shared types and pointer helpers for the DSP sample-file FIFO store.
// Optional occupancy outputs are enabled with the DSP_FILE_FIFO_COUNT_EN macro.
package dsp_file_fifo_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } fsm_state_t;

    localparam int FILE_SEL_W = 8;
    localparam int EXT_PTR_W  = 32;

    function automatic int fidx_width(input int num_files);
        return (num_files > 1) ? $clog2(num_files) : 1;
    endfunction

    function automatic logic ptr_empty(input logic [31:0] rd, input logic [31:0] wr);
        return (rd == wr);
    endfunction

    // Pointers are {wrap, index}; full means only the wrap bit differs.
    function automatic logic ptr_full(input logic [31:0] rd, input logic [31:0] wr,
                                      input int depth_log2);
        logic [31:0] idx_mask;
        idx_mask = (32'd1 << depth_log2) - 32'd1;
        return (((rd ^ wr) & ~idx_mask) == (32'd1 << depth_log2)) &&
               (((rd ^ wr) & idx_mask) == 32'd0);
    endfunction

endpackage

// File: rtl/dsp_file_fifo_if.sv
// Engine handshake and host push/clear bus of the sample-file store.
// With DSP_FILE_FIFO_COUNT_EN the bus also carries file_count and almost_full.
interface dsp_file_fifo_if
    import dsp_file_fifo_pkg::*;
#(
    parameter int dw         = 32,
    parameter int DEPTH_LOG2 = 6
);
    logic [FILE_SEL_W-1:0] file_num;
    logic                  file_read;
    logic                  file_write;
    logic [dw-1:0]         file_write_data;
    logic [dw-1:0]         file_read_data;
    logic                  file_active;
    logic [EXT_PTR_W-1:0]  rd_ptr;
    logic [EXT_PTR_W-1:0]  wr_ptr;
    logic                  host_push;
    logic [FILE_SEL_W-1:0] host_file;
    logic [dw-1:0]         host_push_data;
    logic                  host_clear;
    logic                  overflow;
    logic                  underflow;
    logic                  bad_file;
    logic                  err_clear;
`ifdef DSP_FILE_FIFO_COUNT_EN
    logic [DEPTH_LOG2:0]   file_count;
    logic                  almost_full;
`endif

    modport master (
        output file_num, file_read, file_write, file_write_data,
        output host_push, host_file, host_push_data, host_clear, err_clear,
        input  file_read_data, file_active, rd_ptr, wr_ptr,
        input  overflow, underflow, bad_file
`ifdef DSP_FILE_FIFO_COUNT_EN
        , input file_count, almost_full
`endif
    );

    modport slave (
        input  file_num, file_read, file_write, file_write_data,
        input  host_push, host_file, host_push_data, host_clear, err_clear,
        output file_read_data, file_active, rd_ptr, wr_ptr,
        output overflow, underflow, bad_file
`ifdef DSP_FILE_FIFO_COUNT_EN
        , output file_count, almost_full
`endif
    );

endinterface

// File: rtl/dsp_file_ptr.sv
// Read/write pointer pair of one circular file, {wrap, index} format.
module dsp_file_ptr
    import dsp_file_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
)(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_rd_adv,
    input  logic                i_wr_adv,
    output logic [DEPTH_LOG2:0] o_rd_ptr,
    output logic [DEPTH_LOG2:0] o_wr_ptr,
    output logic                o_empty,
    output logic                o_full
);

    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DEPTH_LOG2:0] r_rd;
    logic [DEPTH_LOG2:0] r_wr;

    // Clear overrides any advance in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd <= {(DEPTH_LOG2+1){1'b0}};
            r_wr <= {(DEPTH_LOG2+1){1'b0}};
        end else if (i_clear) begin
            r_rd <= {(DEPTH_LOG2+1){1'b0}};
            r_wr <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (i_rd_adv) begin
                r_rd <= r_rd + PTR_ONE;
            end else begin
                r_rd <= r_rd;
            end
            if (i_wr_adv) begin
                r_wr <= r_wr + PTR_ONE;
            end else begin
                r_wr <= r_wr;
            end
        end
    end

    assign o_rd_ptr = r_rd;
    assign o_wr_ptr = r_wr;
    assign o_empty  = ptr_empty(32'(r_rd), 32'(r_wr));
    assign o_full   = ptr_full(32'(r_rd), 32'(r_wr), DEPTH_LOG2);

endmodule

// File: rtl/dsp_file_fifo.sv
// NUM_FILES circular sample files in one array, shared by a host push port and an engine handshake.
// Optional DSP_FILE_FIFO_COUNT_EN adds file_count / almost_full.
module dsp_file_fifo
    import dsp_file_fifo_pkg::*;
#(
    parameter int dw         = 32,
    parameter int NUM_FILES  = 4,
    parameter int DEPTH_LOG2 = 6
)(
    input  logic           wb_clk,
    input  logic           wb_rst,
    dsp_file_fifo_if.slave bus
);

    localparam int FIDX_W = fidx_width(NUM_FILES);
    localparam int PTR_W  = DEPTH_LOG2 + 1;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int ADDR_W = FIDX_W + DEPTH_LOG2;

    logic                 w_eng_valid;
    logic                 w_host_valid;
    logic [FIDX_W-1:0]    w_eng_idx;
    logic [FIDX_W-1:0]    w_host_idx;
    logic [PTR_W-1:0]     w_rd_ptr [NUM_FILES];
    logic [PTR_W-1:0]     w_wr_ptr [NUM_FILES];
    logic [NUM_FILES-1:0] w_empty;
    logic [NUM_FILES-1:0] w_full;
    logic [NUM_FILES-1:0] w_clear;
    logic [NUM_FILES-1:0] w_rd_adv;
    logic [NUM_FILES-1:0] w_wr_adv;
    logic                 w_start_rd;
    logic                 w_start_wr;
    logic                 w_host_wr;
    logic                 w_host_ovf;
    logic                 w_host_bad;
    logic                 w_eng_rd;
    logic                 w_eng_wr;
    logic                 w_eng_ovf;
    logic                 w_eng_unf;
    logic                 w_eng_bad;
    logic [ADDR_W-1:0]    w_eng_raddr;
    logic [ADDR_W-1:0]    w_eng_waddr;
    logic [ADDR_W-1:0]    w_host_addr;

    logic [dw-1:0]        r_mem [NUM_FILES*DEPTH];
    fsm_state_t           r_state;
    logic                 r_active;
    logic [dw-1:0]        r_rd_data;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 r_bad;

    assign w_eng_valid  = (32'(bus.file_num) < 32'(NUM_FILES));
    assign w_host_valid = (32'(bus.host_file) < 32'(NUM_FILES));
    assign w_eng_idx    = bus.file_num[FIDX_W-1:0];
    assign w_host_idx   = bus.host_file[FIDX_W-1:0];
    assign w_eng_raddr  = {w_eng_idx, w_rd_ptr[w_eng_idx][DEPTH_LOG2-1:0]};
    assign w_eng_waddr  = {w_eng_idx, w_wr_ptr[w_eng_idx][DEPTH_LOG2-1:0]};
    assign w_host_addr  = {w_host_idx, w_wr_ptr[w_host_idx][DEPTH_LOG2-1:0]};

    for (genvar g = 0; g < NUM_FILES; g++) begin : g_file
        assign w_clear[g]  = bus.host_clear && w_host_valid && (w_host_idx == FIDX_W'(g));
        assign w_rd_adv[g] = w_eng_rd && (w_eng_idx == FIDX_W'(g));
        assign w_wr_adv[g] = (w_host_wr && (w_host_idx == FIDX_W'(g))) ||
                             (w_eng_wr && (w_eng_idx == FIDX_W'(g)));

        dsp_file_ptr #(.DEPTH_LOG2(DEPTH_LOG2)) u_ptr (
            .i_clk    (wb_clk),
            .i_rst    (wb_rst),
            .i_clear  (w_clear[g]),
            .i_rd_adv (w_rd_adv[g]),
            .i_wr_adv (w_wr_adv[g]),
            .o_rd_ptr (w_rd_ptr[g]),
            .o_wr_ptr (w_wr_ptr[g]),
            .o_empty  (w_empty[g]),
            .o_full   (w_full[g])
        );
    end

    // Host push decode; a clear on the same cycle swallows the push.
    always_comb begin
        w_host_wr  = 1'b0;
        w_host_ovf = 1'b0;
        w_host_bad = 1'b0;
        if (bus.host_push && !bus.host_clear) begin
            if (!w_host_valid) begin
                w_host_bad = 1'b1;
            end else if (w_full[w_host_idx]) begin
                w_host_ovf = 1'b1;
            end else begin
                w_host_wr = 1'b1;
            end
        end else begin
            w_host_wr = 1'b0;
        end
    end

    // Engine op decode; a host push to the same file defers the engine write by a cycle.
    always_comb begin
        w_start_rd = (r_state == ST_IDLE) && bus.file_read;
        w_start_wr = (r_state == ST_IDLE) && !bus.file_read && bus.file_write &&
                     !(bus.host_push && (bus.host_file == bus.file_num));
        w_eng_rd   = 1'b0;
        w_eng_wr   = 1'b0;
        w_eng_ovf  = 1'b0;
        w_eng_unf  = 1'b0;
        w_eng_bad  = 1'b0;
        if (w_start_rd) begin
            if (!w_eng_valid) begin
                w_eng_bad = 1'b1;
            end else if (w_empty[w_eng_idx]) begin
                w_eng_unf = 1'b1;
            end else begin
                w_eng_rd = 1'b1;
            end
        end else if (w_start_wr) begin
            if (!w_eng_valid) begin
                w_eng_bad = 1'b1;
            end else if (w_full[w_eng_idx]) begin
                w_eng_ovf = 1'b1;
            end else begin
                w_eng_wr = 1'b1;
            end
        end else begin
            w_eng_rd = 1'b0;
        end
    end

    // Sample storage: host and engine writes always target different files.
    always_ff @(posedge wb_clk) begin
        if (w_host_wr) begin
            r_mem[w_host_addr] <= bus.host_push_data;
        end
        if (w_eng_wr) begin
            r_mem[w_eng_waddr] <= bus.file_write_data;
        end
    end

    // Engine handshake FSM with registered read data, active flag and sticky errors.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state   <= ST_IDLE;
            r_active  <= 1'b0;
            r_rd_data <= {dw{1'b0}};
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rd) begin
                        r_rd_data <= w_eng_rd ? r_mem[w_eng_raddr] : {dw{1'b0}};
                        r_active  <= 1'b1;
                        r_state   <= ST_ACTIVE;
                    end else if (w_start_wr) begin
                        r_active  <= 1'b1;
                        r_state   <= ST_ACTIVE;
                    end else begin
                        r_active  <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (bus.file_read || bus.file_write) begin
                        r_active <= 1'b1;
                        r_state  <= ST_ACTIVE;
                    end else begin
                        r_active <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_active <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase

            if (bus.err_clear) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
                r_bad <= 1'b0;
            end else begin
                r_ovf <= r_ovf | w_host_ovf | w_eng_ovf;
                r_unf <= r_unf | w_eng_unf;
                r_bad <= r_bad | w_host_bad | w_eng_bad;
            end
        end
    end

    assign bus.file_read_data = r_rd_data;
    assign bus.file_active    = r_active;
    assign bus.overflow       = r_ovf;
    assign bus.underflow      = r_unf;
    assign bus.bad_file       = r_bad;
    assign bus.rd_ptr         = w_eng_valid ? 32'(w_rd_ptr[w_eng_idx]) : 32'd0;
    assign bus.wr_ptr         = w_eng_valid ? 32'(w_wr_ptr[w_eng_idx]) : 32'd0;

`ifdef DSP_FILE_FIFO_COUNT_EN
    logic w_almost_full;

    assign bus.file_count = w_eng_valid ? (w_wr_ptr[w_eng_idx] - w_rd_ptr[w_eng_idx])
                                        : {PTR_W{1'b0}};

    // Raised when any file is within four words of full.
    always_comb begin
        w_almost_full = 1'b0;
        for (int i = 0; i < NUM_FILES; i++) begin
            w_almost_full = w_almost_full |
                            ((w_wr_ptr[i] - w_rd_ptr[i]) >= PTR_W'(DEPTH - 4));
        end
    end

    assign bus.almost_full = w_almost_full;
`endif

endmodule

// File: tb/tb_dsp_file_fifo.sv
// Self-checking bench for dsp_file_fifo: vector table plus corner-case sequences, read data via scoreboard queue.
module tb_dsp_file_fifo;

    localparam int DW = 32;

    logic wb_clk = 1'b0;
    logic wb_rst = 1'b1;
    always #5 wb_clk = ~wb_clk;

    dsp_file_fifo_if #(.dw(DW), .DEPTH_LOG2(6)) bus ();

    dsp_file_fifo #(.dw(DW), .NUM_FILES(4), .DEPTH_LOG2(6)) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb [$];

    typedef enum logic {OP_PUSH, OP_READ} op_t;
    typedef struct {
        op_t         op;
        logic [7:0]  file;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [31:0] exp_wr;
        logic        exp_unf;
        logic        exp_bad;
    } vec_t;
    vec_t vecs [8];

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic host_push(input logic [7:0] f, input logic [31:0] d);
        bus.host_file      = f;
        bus.host_push_data = d;
        bus.host_push      = 1'b1;
        tick();
        bus.host_push      = 1'b0;
    endtask

    task automatic eng_read(input logic [7:0] f, input logic [31:0] exp);
        int k;
        logic [31:0] want;
        bus.file_num  = f;
        bus.file_read = 1'b1;
        sb.push_back(exp);
        k = 0;
        tick();
        while (!bus.file_active && k < 8) begin
            tick();
            k++;
        end
        check("read_active", 32'(bus.file_active), 32'd1);
        want = sb.pop_front();
        check("read_data", bus.file_read_data, want);
        bus.file_read = 1'b0;
        tick();
        check("read_release", 32'(bus.file_active), 32'd0);
    endtask

    initial begin
        bus.file_num = 8'd0;  bus.file_read = 1'b0;  bus.file_write = 1'b0;
        bus.file_write_data = 32'd0;  bus.host_push = 1'b0;  bus.host_file = 8'd0;
        bus.host_push_data = 32'd0;  bus.host_clear = 1'b0;  bus.err_clear = 1'b0;

        vecs[0] = '{OP_PUSH, 8'd1, 32'h11, 32'd0, 32'd1, 1'b0, 1'b0};
        vecs[1] = '{OP_PUSH, 8'd1, 32'h22, 32'd0, 32'd2, 1'b0, 1'b0};
        vecs[2] = '{OP_PUSH, 8'd1, 32'h33, 32'd0, 32'd3, 1'b0, 1'b0};
        vecs[3] = '{OP_READ, 8'd1, 32'h11, 32'd1, 32'd3, 1'b0, 1'b0};
        vecs[4] = '{OP_READ, 8'd1, 32'h22, 32'd2, 32'd3, 1'b0, 1'b0};
        vecs[5] = '{OP_READ, 8'd1, 32'h33, 32'd3, 32'd3, 1'b0, 1'b0};
        vecs[6] = '{OP_READ, 8'd0, 32'h0,  32'd0, 32'd0, 1'b1, 1'b0};
        vecs[7] = '{OP_READ, 8'd5, 32'h0,  32'd0, 32'd0, 1'b1, 1'b1};

        // reset
        tick();
        tick();
        wb_rst = 1'b0;
        check("rst_active", 32'(bus.file_active), 32'd0);
        check("rst_data", bus.file_read_data, 32'd0);
        check("rst_errors", {29'd0, bus.overflow, bus.underflow, bus.bad_file}, 32'd0);
        check("rst_rd_ptr", bus.rd_ptr, 32'd0);
        check("rst_wr_ptr", bus.wr_ptr, 32'd0);

        // vector table
        for (int i = 0; i < 8; i++) begin
            bus.file_num = vecs[i].file;
            if (vecs[i].op == OP_PUSH) begin
                host_push(vecs[i].file, vecs[i].data);
            end else begin
                eng_read(vecs[i].file, vecs[i].data);
            end
            check("vec_rd_ptr", bus.rd_ptr, vecs[i].exp_rd);
            check("vec_wr_ptr", bus.wr_ptr, vecs[i].exp_wr);
            check("vec_underflow", 32'(bus.underflow), 32'(vecs[i].exp_unf));
            check("vec_bad_file", 32'(bus.bad_file), 32'(vecs[i].exp_bad));
        end

        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        check("errclr_underflow", 32'(bus.underflow), 32'd0);
        check("errclr_bad_file", 32'(bus.bad_file), 32'd0);

        // fill file 2 to full, then overflow
        bus.file_num = 8'd2;
        for (int i = 0; i < 64; i++) begin
            host_push(8'd2, 32'h200 + 32'(i));
        end
        check("fill_wr_ptr", bus.wr_ptr, 32'h40);
        check("fill_overflow", 32'(bus.overflow), 32'd0);
`ifdef DSP_FILE_FIFO_COUNT_EN
        check("fill_count", 32'(bus.file_count), 32'h40);
        check("fill_almost_full", 32'(bus.almost_full), 32'd1);
`endif
        host_push(8'd2, 32'h2AA);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_wr_ptr", bus.wr_ptr, 32'h40);
        eng_read(8'd2, 32'h200);
        check("full_read_rd_ptr", bus.rd_ptr, 32'd1);
        host_push(8'd2, 32'h2BB);
        check("refill_wr_ptr", bus.wr_ptr, 32'h41);
        bus.err_clear = 1'b1;
        host_push(8'd2, 32'h2CC);
        bus.err_clear = 1'b0;
        check("errclr_priority", 32'(bus.overflow), 32'd0);
        check("errclr_wr_ptr", bus.wr_ptr, 32'h41);

        // host push and engine write to file 3 in the same cycle
        bus.file_num        = 8'd3;
        bus.file_write      = 1'b1;
        bus.file_write_data = 32'hBBBB;
        bus.host_file       = 8'd3;
        bus.host_push_data  = 32'hAAAA;
        bus.host_push       = 1'b1;
        tick();
        bus.host_push = 1'b0;
        check("conflict_active_deferred", 32'(bus.file_active), 32'd0);
        check("conflict_wr_ptr_host", bus.wr_ptr, 32'd1);
        tick();
        check("conflict_active_rise", 32'(bus.file_active), 32'd1);
        check("conflict_wr_ptr_eng", bus.wr_ptr, 32'd2);
        bus.file_write = 1'b0;
        tick();
        check("conflict_release", 32'(bus.file_active), 32'd0);
        eng_read(8'd3, 32'hAAAA);
        eng_read(8'd3, 32'hBBBB);

        // clear wins over same-cycle push
        bus.file_num = 8'd0;
        host_push(8'd0, 32'h55);
        check("clr_pre_wr_ptr", bus.wr_ptr, 32'd1);
        bus.host_clear = 1'b1;
        host_push(8'd0, 32'h66);
        bus.host_clear = 1'b0;
        check("clr_rd_ptr", bus.rd_ptr, 32'd0);
        check("clr_wr_ptr", bus.wr_ptr, 32'd0);

        // reset in the middle of an engine write
        bus.file_num        = 8'd1;
        bus.file_write      = 1'b1;
        bus.file_write_data = 32'h77;
        tick();
        check("rstmid_active", 32'(bus.file_active), 32'd1);
        wb_rst = 1'b1;
        tick();
        check("rstmid_active_drop", 32'(bus.file_active), 32'd0);
        check("rstmid_wr_ptr", bus.wr_ptr, 32'd0);
        bus.file_write = 1'b0;
        wb_rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
